// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Sequential restoring divider for the EX stage. One quotient
//               bit per clock, 32 iterations, signed or unsigned, with
//               divide-by-zero short path and pipeline-flush cancellation.
//               result_o = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    // Iteration count at which all quotient bits have been produced.
    localparam logic [5:0] C_LAST_ITER = 6'(WIDTH);

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // divisor magnitude
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // Operand magnitudes taken at the accept edge.
    logic                 w_op1_neg;
    logic                 w_op2_neg;
    logic [WIDTH-1:0]     w_op1_mag;
    logic [WIDTH-1:0]     w_op2_mag;

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor. The remainder is always below the divisor,
    // so the trial value fits in WIDTH+1 bits and a fitting difference in WIDTH.
    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_fit;

    // Sign fix-up applied when the result is loaded.
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    assign w_trial   = {rem_q, quo_q[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, dvs_q};
    assign w_fit     = ~w_diff[WIDTH];

    assign w_quo_fix = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
    assign w_rem_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

    // Next-state, working-register and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    quo_d     = w_op1_mag;
                    rem_d     = '0;
                    dvs_d     = w_op2_mag;
                    quo_neg_d = w_op1_neg ^ w_op2_neg;
                    rem_neg_d = w_op1_neg;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    // Flush: drop all partial work.
                    state_d   = S_FREE;
                    ready_d   = 1'b0;
                    result_d  = '0;
                    cnt_d     = '0;
                    quo_d     = '0;
                    rem_d     = '0;
                    dvs_d     = '0;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                end else if (cnt_q == C_LAST_ITER) begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {w_rem_fix, w_quo_fix};
                end else begin
                    rem_d = w_fit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], w_fit};
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_END: begin
                // Result is held for the requester; flushes do not apply here.
                if (!start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_FREE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Directed self-checking bench for div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int errors;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full divide: accept edge, 32 iteration edges with ready low, result on
    // edge 33, then release start and confirm the return to FREE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        logic early;
        early        = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        tick();                         // accept edge 0
        // Scramble operands: must not disturb the latched request.
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'h0000_0000;
        signed_div_i = ~sgn;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (ready_o) early = 1'b1;
        end
        check({tag, "_early"}, {63'd0, early}, 64'd0);
        tick();                         // edge 33
        check({tag, "_rdy"}, {63'd0, ready_o}, 64'd1);
        check({tag, "_res"}, result_o, exp);
        tick();                         // start held: result holds
        check({tag, "_hold"}, result_o, exp);
        start_i = 1'b0;
        tick();
        check({tag, "_free_rdy"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_free_res"}, result_o, 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        // Reset state.
        #12;
        check("rst_rdy", {63'd0, ready_o}, 64'd0);
        check("rst_res", result_o, 64'd0);
        #10;
        rst = 1'b1;                     // released between edges
        #2;

        // Basic unsigned and signed cases.
        run_div("u100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E);
        run_div("s_m7_2",  1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD);
        run_div("u_m7_2",  1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC);
        run_div("s_min_m1",1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000);
        // 7 / -2 signed: quo -3, rem +1.
        run_div("s_7_m2",  1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD);
        // Unsigned full-range: 0xFFFFFFFF / 0x10 = 0x0FFFFFFF rem 0xF.
        run_div("u_max_16",1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  64'h0000000F_0FFFFFFF);

        // Divide by zero, both modes.
        for (int m = 0; m < 2; m++) begin
            signed_div_i = m[0];
            opdata1_i    = 32'd55;
            opdata2_i    = 32'd0;
            start_i      = 1'b1;
            tick();
            check("dz_acc_rdy", {63'd0, ready_o}, 64'd0);
            tick();
            check("dz_rdy", {63'd0, ready_o}, 64'd1);
            check("dz_res", result_o, 64'd0);
            start_i = 1'b0;
            tick();
            check("dz_free", {63'd0, ready_o}, 64'd0);
        end

        // Annul at edge 10 of ON; ready must never rise.
        begin
            logic seen;
            seen         = 1'b0;
            signed_div_i = 1'b0;
            opdata1_i    = 32'd1000;
            opdata2_i    = 32'd3;
            start_i      = 1'b1;
            tick();
            for (int i = 1; i <= 9; i++) tick();
            annul_i = 1'b1;
            start_i = 1'b0;
            tick();
            annul_i = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ready_o) seen = 1'b1;
            end
            check("annul_never", {63'd0, seen}, 64'd0);
        end
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Annul in FREE blocks acceptance for that edge.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        tick();
        run_div("u50_5_afterannul", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

        // Annul in END has no effect.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        tick();
        tick();
        annul_i = 1'b1;
        tick();
        check("end_annul_rdy", {63'd0, ready_o}, 64'd1);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();

        // Reset mid-ON at iteration 20, asserted between edges.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_on_rdy", {63'd0, ready_o}, 64'd0);
        check("rst_on_res", result_o, 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        run_div("u77_7_afterrst", 1'b0, 32'd77, 32'd7, 64'h00000000_0000000B);

        // Reset in END clears a valid result immediately.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd20;
        opdata2_i    = 32'd6;
        start_i      = 1'b1;
        for (int i = 0; i <= 33; i++) tick();
        check("end_pre_rst", result_o, 64'h00000002_00000003);
        #2;
        rst = 1'b0;
        #1;
        check("rst_end_rdy", {63'd0, ready_o}, 64'd0);
        check("rst_end_res", result_o, 64'd0);
        start_i = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        tick();
        check("rst_end_noresume", {63'd0, ready_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width; result width is 2*WIDTH; only 32 is supported.
REQ-002 clk  input  1  clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; rst==0 resets the block.
REQ-004 signed_div_i  input  1  1 = signed divide, 0 = unsigned.
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  request; held high by the EX stage until ready_o is seen.
REQ-008 annul_i  input  1  cancels an in-flight divide (pipeline flush).
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  result_o valid.

Function
REQ-011 The block SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-012 All outputs SHALL be registered.
REQ-013 In FREE, ready_o=0 and result_o=0.
REQ-014 In FREE, start_i=1 && annul_i=0 on an edge (the accept edge) SHALL latch the operands and signed_div_i, then go to BYZERO if opdata2_i==0, else to ON with iteration count 0.
REQ-015 In FREE with annul_i=1, start_i SHALL be ignored.
REQ-016 Operand or signed_div_i changes after the accept edge SHALL have no effect on the result.
REQ-017 In signed mode, the magnitudes (two's-complement negation of negative operands) SHALL be divided; in unsigned mode the raw values are divided.
REQ-018 In ON, each edge with annul_i=0 SHALL perform one restoring-division step, producing one quotient bit, MSB first.
REQ-019 Iterations SHALL occur on edges 1..32 after the accept edge.
REQ-020 On edge 33, with count==32, the block SHALL apply sign fix-up, load result_o, set ready_o=1 and go to END.
REQ-021 ready_o SHALL be first high in the cycle following edge 33 after the accept edge.
REQ-022 Sign fix-up applies in signed mode only:
- quotient is negated when the dividend and divisor signs differ;
- remainder is negated when the dividend is negative;
- remainder magnitude is always less than the divisor magnitude.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 (wrap) and remainder 0.
REQ-024 Any edge in ON with annul_i=1 SHALL go to FREE with ready_o=0 and result_o=0; partial state is discarded.
REQ-025 BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1; annul_i=1 on that edge SHALL go to FREE instead.
REQ-026 In END, ready_o=1 and result_o SHALL be held while start_i=1.
REQ-027 In END, start_i=0 on an edge SHALL go to FREE with ready_o=0 and result_o=0.
REQ-028 annul_i SHALL have no effect in END.
REQ-029 A new request SHALL need a return to FREE first; back-to-back divides are separated by at least one FREE cycle.
REQ-030 The iteration counter SHALL be 6 bits and SHALL NOT wrap; it is cleared on acceptance.

Reset
REQ-031 rst=0 SHALL, asynchronously and in any state, force state=FREE, ready_o=0, result_o=0, and clear the counter and working registers.
REQ-032 The first accept edge SHALL be the first rising edge after rst returns high with start_i=1.
REQ-033 Reset during ON or END SHALL produce no result; the aborted request is not resumed.

Verification
REQ-034 Unsigned 100/7: accept at edge 0 -> ready_o rises after edge 33, result_o=0x00000002_0000000E; ready_o is low before that.
REQ-035 Signed 0xFFFFFFF9/2 (-7/2) -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3); the same operands unsigned -> 0x00000001_7FFFFFFC.
REQ-036 Divisor 0 (either mode) -> ready_o high after edge 1, result_o=0; deasserting start_i -> FREE, ready_o=0 on the next edge.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000 after edge 33.
REQ-038 annul_i pulsed at edge 10 of ON -> FREE, ready_o never asserts; a fresh 9/3 request accepted afterwards -> result_o=0x00000000_00000003, full latency.
REQ-039 rst driven low mid-ON (iteration 20), between edges -> ready_o=0 and result_o=0 immediately; after release with start_i=1 the next edge is an accept edge and the full 33-edge latency applies.
